ring_osc_freq_counter: RTL and testbench
========================================

// Module: ring_osc_freq_counter
// PURPOSE
//   Measures the output of the inverter-chain ring oscillator / delay line
//   by counting its rising edges over a programmable window of clk cycles.
//   Sits between the chain output and the user/debug register interface.
//   The result is a frequency code: f_osc ~= result * f_clk / gate_cycles.
//   Edges are resolvable only for f_osc < f_clk/2; faster inputs alias.
// PARAMETERS
//   SYNC_STAGES  2   flops in the osc_in synchronizer (>=2)
//   GATE_W       16  width of gate_cycles (window length in clk cycles)
//   COUNT_W      16  width of edge counter and result
// PORTS
//   clk          in   1        system clock
//   rst          in   1        asynchronous, active-high reset
//   osc_in       in   1        chain output; asynchronous to clk
//   start        in   1        pulse; begins a measurement when idle
//   gate_cycles  in   GATE_W   window length; sampled on accepted start
//   busy         out  1        high while a measurement is in progress
//   done         out  1        one-cycle pulse when result updates
//   result       out  COUNT_W  rising-edge count of the last window
//   overflow     out  1        last window's count saturated
// BEHAVIOUR
//   Interface: one clock (clk); reset rst is asynchronous, active-high.
//   Reset values: busy=0, done=0, result=0, overflow=0. Internal: state=IDLE,
//     sync chain=0, edge-detect flop=0, counters=0.
//   Synchronizer: osc_in passes through SYNC_STAGES flops, then one
//     edge-detect flop. edge = sync_out & ~prev. The synchronizer and
//     edge-detect flop run in every state, so entering COUNT does not
//     produce a spurious edge.
//   FSM states: IDLE, COUNT, DONE.
//   - IDLE: if start=1, latch G=gate_cycles and clear edge_cnt.
//     If G!=0, go to COUNT and load win=G. If G==0, go to DONE.
//     Otherwise stay in IDLE.
//   - COUNT: on each cycle, if edge=1 then edge_cnt++ (saturating at
//     2^COUNT_W-1); a saturating attempt sets ovf_int. win decrements by 1.
//     When win==1, go to DONE after this cycle's edge is counted.
//     COUNT lasts exactly G cycles.
//   - DONE: result<=edge_cnt, overflow<=ovf_int, done=1 for this one
//     cycle, then go to IDLE.
//   Timing: start accepted at cycle T gives COUNT on T+1..T+G, done and the
//     new result at T+G+1. busy=1 from T+1 through T+G+1 inclusive.
//   start while busy is ignored. No queueing and no restart.
//   result/overflow hold their value between done pulses.
//   A start asserted in the same cycle as done (the DONE state) is ignored;
//     the next start is accepted in IDLE.
//   Edges are counted only in COUNT. Edges in IDLE/DONE are discarded.
//   Synchronizer latency (SYNC_STAGES+1) shifts the window relative to the
//     pin. This shift is accepted, not compensated.
//   Reset mid-measurement: returns to IDLE immediately and clears result and
//     overflow. No done pulse is produced.
// TESTING
//   1. osc_in period 10 clk (50% duty), gate_cycles=100 -> done at T+101,
//      result=10 (+/-1 for phase), overflow=0, busy high 101 cycles.
//   2. gate_cycles=0 -> done at T+1, result=0, busy high 1 cycle.
//   3. COUNT_W=4, osc period 4 clk, gate_cycles=200 -> result=15, overflow=1.
//      A following run with gate_cycles=8 -> result=2, overflow=0.
//   4. start pulsed again mid-window and in the DONE cycle -> ignored; single
//      done at T+G+1; result matches a single-start run.
//   5. rst asserted mid-COUNT (async, between clk edges) -> busy/done/result/
//      overflow 0 immediately. Next start measures correctly from zero.
//   6. osc_in held high across start, then toggled -> no edge counted at
//      COUNT entry; result equals true in-window rising edges only.

Source files
------------

// File: rtl/ring_osc_freq_counter_if.sv
// ring_osc_freq_counter_if: measurement request/result bundle for the ring oscillator frequency counter
//   master drives osc_in, start, gate_cycles; slave drives busy, done, result, overflow
interface ring_osc_freq_counter_if #(
    parameter int GATE_W  = 16,
    parameter int COUNT_W = 16
);
    logic               osc_in;
    logic               start;
    logic [GATE_W-1:0]  gate_cycles;
    logic               busy;
    logic               done;
    logic [COUNT_W-1:0] result;
    logic               overflow;
    modport master (output osc_in, start, gate_cycles, input busy, done, result, overflow);
    modport slave  (input osc_in, start, gate_cycles, output busy, done, result, overflow);
endinterface

// File: rtl/ring_osc_freq_counter.sv
// ring_osc_freq_counter: counts synchronized rising edges of osc_in over a window of gate_cycles clk cycles
//   clk, rst (async, active-high); bus.slave: osc_in, start, gate_cycles in; busy, done, result, overflow out
module ring_osc_freq_counter #(
    parameter int SYNC_STAGES = 2,
    parameter int GATE_W      = 16,
    parameter int COUNT_W     = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    ring_osc_freq_counter_if.slave   bus
);
    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;
    state_t                 r_state, w_state_n;
    logic [SYNC_STAGES-1:0] r_sync;
    logic                   r_prev;
    logic [GATE_W-1:0]      r_win, w_win_n;
    logic [COUNT_W-1:0]     r_cnt, w_cnt_n, r_result;
    logic                   r_ovf, w_ovf_n, r_overflow;
    logic                   w_edge, w_sat;
    // synchronizer and edge flop run in every state so COUNT entry never sees a stale edge
    assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;
    assign w_sat  = &r_cnt;
    always_comb begin
        w_state_n = r_state;
        w_win_n   = r_win;
        w_cnt_n   = r_cnt;
        w_ovf_n   = r_ovf;
        case (r_state)
            IDLE: if (bus.start) begin
                w_cnt_n   = '0;
                w_ovf_n   = 1'b0;
                w_win_n   = bus.gate_cycles;
                w_state_n = (bus.gate_cycles == '0) ? DONE : COUNT;
            end
            COUNT: begin
                w_win_n = r_win - 1'b1;
                if (w_edge) begin
                    w_cnt_n = w_sat ? r_cnt : r_cnt + 1'b1;
                    w_ovf_n = r_ovf | w_sat;
                end
                if (r_win == GATE_W'(1)) w_state_n = DONE;
            end
            default: w_state_n = IDLE;
        endcase
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= IDLE;
            r_sync     <= '0;
            r_prev     <= 1'b0;
            r_win      <= '0;
            r_cnt      <= '0;
            r_ovf      <= 1'b0;
            r_result   <= '0;
            r_overflow <= 1'b0;
        end else begin
            r_state <= w_state_n;
            r_sync  <= {r_sync[SYNC_STAGES-2:0], bus.osc_in};
            r_prev  <= r_sync[SYNC_STAGES-1];
            r_win   <= w_win_n;
            r_cnt   <= w_cnt_n;
            r_ovf   <= w_ovf_n;
            // publish on DONE entry so result is already valid while done is high
            if (w_state_n == DONE) begin
                r_result   <= w_cnt_n;
                r_overflow <= w_ovf_n;
            end
        end
    end
    assign bus.busy     = r_state != IDLE;
    assign bus.done     = r_state == DONE;
    assign bus.result   = r_result;
    assign bus.overflow = r_overflow;
endmodule

// File: tb/tb_ring_osc_freq_counter.sv
// tb_ring_osc_freq_counter: scoreboard bench for ring_osc_freq_counter (16-bit and 4-bit count instances)
module tb_ring_osc_freq_counter;
    localparam int S = 2;
    typedef struct {int e0; int g; int res; int ovf;} exp_t;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic osc = 1'b0;
    int   cyc = 0;
    int   n_tot = 0;
    int   n_bad = 0;
    int   per = 10, base = 0, hold_until = 0;
    bit   hold_val = 1'b0;
    int   bc_a = 0, bc_b = 0;
    exp_t q_a[$], q_b[$];
    ring_osc_freq_counter_if #(.GATE_W(16), .COUNT_W(16)) ifa ();
    ring_osc_freq_counter_if #(.GATE_W(16), .COUNT_W(4))  ifb ();
    ring_osc_freq_counter #(.SYNC_STAGES(S), .GATE_W(16), .COUNT_W(16)) dut_a (.clk(clk), .rst(rst), .bus(ifa.slave));
    ring_osc_freq_counter #(.SYNC_STAGES(S), .GATE_W(16), .COUNT_W(4))  dut_b (.clk(clk), .rst(rst), .bus(ifb.slave));
    assign ifa.osc_in = osc;
    assign ifb.osc_in = osc;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    function automatic bit lvl(int k);
        if (k < 0) return 1'b0;
        if (k < hold_until) return hold_val;
        return ((k - base) % per) < (per / 2);
    endfunction
    always @(negedge clk) osc = lvl(cyc);
    function automatic exp_t mk(int e0, int g, int w);
        exp_t e;
        int raw = 0;
        int mx = (1 << w) - 1;
        for (int k = e0 + 1 - S; k <= e0 + g - S; k++) if (lvl(k) && !lvl(k - 1)) raw++;
        e.e0  = e0;
        e.g   = g;
        e.res = (raw > mx) ? mx : raw;
        e.ovf = (raw > mx) ? 1 : 0;
        return e;
    endfunction
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tot++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0d exp=%0d at cyc=%0d", tag, got, exp, cyc);
        end
    endtask
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q_a.delete();
            bc_a = 0;
        end else begin
            if (ifa.busy) bc_a++;
            if (ifa.done) begin
                if (q_a.size() == 0) chk("a_spurious_done", 1, 0);
                else begin
                    e = q_a.pop_front();
                    chk("a_result", 32'(ifa.result), e.res);
                    chk("a_ovf", 32'(ifa.overflow), e.ovf);
                    chk("a_done_cyc", cyc, e.e0 + e.g + 1);
                    chk("a_busy_len", bc_a, e.g + 1);
                end
                bc_a = 0;
            end
        end
    end
    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            q_b.delete();
            bc_b = 0;
        end else begin
            if (ifb.busy) bc_b++;
            if (ifb.done) begin
                if (q_b.size() == 0) chk("b_spurious_done", 1, 0);
                else begin
                    e = q_b.pop_front();
                    chk("b_result", 32'(ifb.result), e.res);
                    chk("b_ovf", 32'(ifb.overflow), e.ovf);
                    chk("b_done_cyc", cyc, e.e0 + e.g + 1);
                    chk("b_busy_len", bc_b, e.g + 1);
                end
                bc_b = 0;
            end
        end
    end
    task automatic drive(input bit sel, input bit st, input int g);
        if (sel) begin
            ifb.start = st;
            ifb.gate_cycles = 16'(g);
        end else begin
            ifa.start = st;
            ifa.gate_cycles = 16'(g);
        end
    endtask
    task automatic measure(input bit sel, input int g, input bit extra);
        bit seen = 1'b0;
        @(negedge clk);
        drive(sel, 1'b1, g);
        if (sel) q_b.push_back(mk(cyc, g, 4));
        else     q_a.push_back(mk(cyc, g, 16));
        for (int i = 0; i < g + 20; i++) begin
            @(negedge clk);
            drive(sel, extra && g > 2 && i == g / 2, 3);
            if (sel ? ifb.done : ifa.done) begin
                seen = 1'b1;
                if (extra) drive(sel, 1'b1, 5);
                break;
            end
        end
        if (!seen) chk("done_timeout", 0, 1);
        @(negedge clk);
        drive(sel, 1'b0, 0);
        if (extra) chk("start_in_done_ignored", 32'(sel ? ifb.busy : ifa.busy), 0);
        repeat (4) @(negedge clk);
    endtask
    initial begin
        #2_000_000;
        $display("FAIL global_timeout got=1 exp=0");
        $fatal(1, "bench timeout");
    end
    initial begin
        drive(1'b0, 1'b0, 0);
        drive(1'b1, 1'b0, 0);
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(ifa.busy), 0);
        chk("rst_done", 32'(ifa.done), 0);
        chk("rst_result", 32'(ifa.result), 0);
        chk("rst_ovf", 32'(ifa.overflow), 0);
        rst = 1'b0;
        repeat (4) @(negedge clk);
        measure(1'b0, 100, 1'b0);
        measure(1'b0, 0, 1'b0);
        per = 4;
        repeat (4) @(negedge clk);
        measure(1'b1, 200, 1'b0);
        measure(1'b1, 8, 1'b0);
        per = 10;
        repeat (4) @(negedge clk);
        measure(1'b0, 40, 1'b1);
        @(negedge clk);
        drive(1'b0, 1'b1, 100);
        q_a.push_back(mk(cyc, 100, 16));
        @(negedge clk);
        drive(1'b0, 1'b0, 0);
        repeat (30) @(negedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_busy", 32'(ifa.busy), 0);
        chk("midrst_done", 32'(ifa.done), 0);
        chk("midrst_result", 32'(ifa.result), 0);
        chk("midrst_ovf", 32'(ifa.overflow), 0);
        chk("midrst_b_result", 32'(ifb.result), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        measure(1'b0, 50, 1'b0);
        hold_val = 1'b1;
        hold_until = cyc + 12;
        base = hold_until;
        per = 6;
        repeat (4) @(negedge clk);
        measure(1'b0, 30, 1'b0);
        measure(1'b1, 8, 1'b0);
        repeat (3) @(negedge clk);
        chk("sb_empty_a", q_a.size(), 0);
        chk("sb_empty_b", q_b.size(), 0);
        $display("test done: total=%0d bad=%0d", n_tot, n_bad);
        $finish;
    end
endmodule
